// File: rtl/pc_sequencer_pkg.sv
// Shared constants, state encoding and small address helpers for the PC sequencer.
package pc_sequencer_pkg;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequencer states (IDLE / FETCH / DELIVER), kept as plain constants.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_FETCH   = 2'd1;
   localparam state_t ST_DELIVER = 2'd2;

   // Clear the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

   // Sign-extend a word-unit branch immediate into a byte displacement.
   function automatic logic [31:0] branch_disp(input logic [15:0] offset);
      return {{14{offset[15]}}, offset, 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_jump_target_gen.sv
// J-type target formation: keeps the upper nibble of the sequential PC and
// splices in the 26-bit word index.
module jump_target_gen
   import pc_sequencer_pkg::*;
(
   input  logic [3:0]  pc_plus4_hi,
   input  logic [25:0] jump_index,
   output logic [31:0] target
);

   assign target = {pc_plus4_hi, jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: fetches one word at a time, hands it to
// decode, then picks the next PC (jump > branch > sequential) or a redirect.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic        pend_r, pend_nxt_s;
   logic [31:0] pend_pc_r, pend_pc_nxt_s;
   logic [31:0] instr_r, instr_nxt_s;
   logic [31:0] instr_pc_r, instr_pc_nxt_s;
   logic        req_r, req_nxt_s;
   logic        valid_r, valid_nxt_s;

   logic [31:0] pc_plus4_s;
   logic [31:0] jump_tgt_s;
   logic [31:0] branch_tgt_s;
   logic [31:0] redir_tgt_s;

   assign pc_plus4_s   = instr_pc_r + PC_INCR;
   assign branch_tgt_s = pc_plus4_s + branch_disp(branch_offset);
   assign redir_tgt_s  = word_align(redirect_pc);

   jump_target_gen u_jump_target_gen (
      .pc_plus4_hi (pc_plus4_s[31:28]),
      .jump_index  (jump_index),
      .target      (jump_tgt_s)
   );

   // Next-state, next-PC and capture logic for the fetch/deliver handshake.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      pend_nxt_s     = pend_r;
      pend_pc_nxt_s  = pend_pc_r;
      instr_nxt_s    = instr_r;
      instr_pc_nxt_s = instr_pc_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_FETCH;
            if (redirect) begin
               pc_nxt_s = redir_tgt_s;
            end else begin
               pc_nxt_s = pc_r;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  // Word belongs to the abandoned path: drop it, refetch at target.
                  pc_nxt_s   = redir_tgt_s;
                  pend_nxt_s = 1'b0;
               end else if (pend_r) begin
                  pc_nxt_s   = pend_pc_r;
                  pend_nxt_s = 1'b0;
               end else begin
                  instr_nxt_s    = imem_rdata;
                  instr_pc_nxt_s = pc_r;
                  state_nxt_s    = ST_DELIVER;
               end
            end else if (redirect) begin
               // The outstanding request must stay stable, so park the target.
               pend_nxt_s    = 1'b1;
               pend_pc_nxt_s = redir_tgt_s;
            end else begin
               pend_nxt_s = pend_r;
            end
         end
         ST_DELIVER: begin
            pend_nxt_s = 1'b0;
            if (redirect) begin
               pc_nxt_s    = redir_tgt_s;
               state_nxt_s = ST_FETCH;
            end else if (instr_ready) begin
               if (jump) begin
                  pc_nxt_s = jump_tgt_s;
               end else if (branch_taken) begin
                  pc_nxt_s = branch_tgt_s;
               end else begin
                  pc_nxt_s = pc_plus4_s;
               end
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_DELIVER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            pend_nxt_s  = 1'b0;
         end
      endcase
      req_nxt_s   = (state_nxt_s == ST_FETCH);
      valid_nxt_s = (state_nxt_s == ST_DELIVER);
   end

   // State, PC and output registers; reset takes effect without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         pc_r       <= word_align(RESET_PC);
         pend_r     <= 1'b0;
         pend_pc_r  <= 32'h0000_0000;
         instr_r    <= 32'h0000_0000;
         instr_pc_r <= 32'h0000_0000;
         req_r      <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         pend_r     <= pend_nxt_s;
         pend_pc_r  <= pend_pc_nxt_s;
         instr_r    <= instr_nxt_s;
         instr_pc_r <= instr_pc_nxt_s;
         req_r      <= req_nxt_s;
         valid_r    <= valid_nxt_s;
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = pc_r;
   assign instr_valid = valid_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory accepted the request; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  decode consumes instr this cycle.
- jump  in  1  consumed instruction is J-type.
- jump_index  in  26  J-type target field.
- branch_taken  in  1  consumed instruction is a taken branch.
- branch_offset  in  16  branch immediate, word units.
- redirect  in  1  asynchronous-to-flow PC override (exception/restart).
- redirect_pc  in  32  override target; bits [1:0] ignored.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high, ports named clk and reset.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DELIVER.
REQ-005 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-007 On imem_ack in FETCH, instr<=imem_rdata, instr_pc<=pc, state<=DELIVER; minimum fetch latency is 1 cycle (ack in first FETCH cycle).
REQ-008 In DELIVER, instr_valid SHALL be 1, imem_req 0; instr/instr_pc SHALL hold until instr_ready.
REQ-009 On instr_valid && instr_ready, next pc SHALL be selected by priority: jump > branch_taken > sequential; state<=FETCH.
REQ-010 Sequential target SHALL be pc_plus4 = instr_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-011 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-012 Branch target SHALL be pc_plus4 + (sign-extended branch_offset << 2), modulo 2^32.
REQ-013 jump, jump_index, branch_taken, branch_offset SHALL be ignored when not (instr_valid && instr_ready).
REQ-014 imem_ack SHALL be ignored outside FETCH.
REQ-015 redirect in IDLE or DELIVER SHALL set pc<={redirect_pc[31:2],2'b00}, drop instr_valid, go to FETCH next cycle; it overrides a same-cycle instr_ready target.
REQ-016 redirect in FETCH without imem_ack SHALL latch a pending redirect; the request stays unchanged until ack, the returned word SHALL be discarded, then FETCH at the redirect target.
REQ-017 redirect in FETCH with same-cycle imem_ack SHALL discard the word and go to FETCH at the redirect target next cycle.
REQ-018 A later redirect while one is pending SHALL replace the pending target.
REQ-019 imem_addr[1:0] and instr_pc[1:0] SHALL always be 2'b00.

Reset
REQ-020 On reset: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, pending redirect cleared, all immediately (no clock required).
REQ-021 Reset asserted mid-FETCH SHALL drop imem_req immediately; a late imem_ack SHALL be ignored.

Structure
REQ-022 Package pc_sequencer_pkg SHALL hold the state enum, PC_INCR=4, and RESET_PC default.
REQ-023 Jump-target formation (REQ-011) SHALL be sub-module jump_target_gen (combinational); all else in pc_sequencer.

Verification
REQ-024 Reset, ack each first FETCH cycle, ready=1 -> imem_addr 0,4,8, one instruction per 2 cycles.
REQ-025 instr_pc=32'h1000_0040, jump=1, jump_index=26'h000_0100 -> next imem_addr 32'h1000_0400.
REQ-026 instr_pc=32'h0000_0100, branch_taken=1, offset 16'hFFFE -> next imem_addr 32'h0000_00FC; jump=1 same cycle -> jump target wins.
REQ-027 redirect_pc=32'h8000_0183 during FETCH with ack delayed 3 cycles -> addr held 3 cycles, word discarded, no instr_valid, next imem_addr 32'h8000_0180.
REQ-028 instr_pc=32'hFFFF_FFFC sequential -> next imem_addr 0; reset mid-FETCH -> imem_req 0 same cycle, pc=RESET_PC.
